mme_tile_sched: RTL

//  Tile-level sequencer for the matrix-multiply engine; computes C = A x B for an N x N matrix with N > SA_WIDTH.

---
 rtl/mme_sched_pkg.sv | 34 +++
 rtl/mme_tile_addr_gen.sv | 76 +++++++
 rtl/mme_tile_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mme_sched_pkg.sv
// Shared types and constants for the matrix-multiply tile sequencer.
//  - sched_state_t : sequencer state encoding
//  - tile_idx_t    : tile index (ti, tj, k) width
//  - mat_bases_t   : latched A/B/C base byte addresses
package mme_sched_pkg;

    localparam int unsigned DW_DEF       = 32;
    localparam int unsigned SA_WIDTH_DEF = 4;
    localparam int unsigned EB           = DW_DEF / 8;
    localparam int unsigned AW           = 32;
    localparam int unsigned NW           = 8;

    typedef logic [NW-1:0] tile_idx_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_LD_REQ,
        S_LD_WAIT,
        S_MM_GO,
        S_MM_WAIT,
        S_ST_REQ,
        S_ST_WAIT,
        S_NEXT,
        S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
    } mat_bases_t;

endpackage

// File: rtl/mme_tile_addr_gen.sv
// Registered tile address generator.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  bases_i           latched A/B/C base byte addresses
//  n_i               matrix width N in elements
//  ti_i, tj_i, k_i   tile indices the sequencer is about to hold
//  ld_a_addr_o       A tile (ti,k) top-left byte address
//  ld_b_addr_o       B tile (k,tj) top-left byte address
//  st_c_addr_o       C tile (ti,tj) top-left byte address
//  stride_o          row stride in bytes (N * element bytes)
module mme_tile_addr_gen
    import mme_sched_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned SA_WIDTH = SA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  mat_bases_t    bases_i,
    input  logic [NW-1:0] n_i,
    input  tile_idx_t     ti_i,
    input  tile_idx_t     tj_i,
    input  tile_idx_t     k_i,
    output logic [AW-1:0] ld_a_addr_o,
    output logic [AW-1:0] ld_b_addr_o,
    output logic [AW-1:0] st_c_addr_o,
    output logic [AW-1:0] stride_o
);

    localparam int unsigned EL_BYTES = DW / 8;

    logic [AW-1:0] w_n;
    logic [AW-1:0] w_row_ti;
    logic [AW-1:0] w_row_k;
    logic [AW-1:0] w_col_k;
    logic [AW-1:0] w_col_tj;
    logic [AW-1:0] w_a_off;
    logic [AW-1:0] w_b_off;
    logic [AW-1:0] w_c_off;

    logic [AW-1:0] r_ld_a;
    logic [AW-1:0] r_ld_b;
    logic [AW-1:0] r_st_c;
    logic [AW-1:0] r_stride;

    // Element offsets of tile corners; all products truncate to 32 bits.
    assign w_n      = AW'(n_i);
    assign w_row_ti = AW'(ti_i) * AW'(SA_WIDTH) * w_n;
    assign w_row_k  = AW'(k_i)  * AW'(SA_WIDTH) * w_n;
    assign w_col_k  = AW'(k_i)  * AW'(SA_WIDTH);
    assign w_col_tj = AW'(tj_i) * AW'(SA_WIDTH);
    assign w_a_off  = (w_row_ti + w_col_k)  * AW'(EL_BYTES);
    assign w_b_off  = (w_row_k  + w_col_tj) * AW'(EL_BYTES);
    assign w_c_off  = (w_row_ti + w_col_tj) * AW'(EL_BYTES);

    // Address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_a   <= '0;
            r_ld_b   <= '0;
            r_st_c   <= '0;
            r_stride <= '0;
        end else begin
            r_ld_a   <= bases_i.a + w_a_off;
            r_ld_b   <= bases_i.b + w_b_off;
            r_st_c   <= bases_i.c + w_c_off;
            r_stride <= w_n * AW'(EL_BYTES);
        end
    end

    assign ld_a_addr_o = r_ld_a;
    assign ld_b_addr_o = r_ld_b;
    assign st_c_addr_o = r_st_c;
    assign stride_o    = r_stride;

endmodule

// File: rtl/mme_tile_sched.sv
// Tile-level sequencer for the matrix-multiply engine (C = A x B, N x N).
// Walks output tiles (ti outer, tj middle) and reduction tiles k (inner);
// each step loads an A/B tile pair then runs one MM pass; after the last k
// of an output tile the C tile is stored.
// Ports:
//  clk, rst                       clock, synchronous active-high reset
//  start_i, mat_width_i           start pulse and matrix width N
//  mat_{a,b,c}_addr_i             matrix base byte addresses
//  busy_o, done_o, err_o          status (done is a pulse, err is sticky)
//  ld_req_o/ld_gnt_i/ld_done_i    tile-load handshake, ld_{a,b}_addr_o, stride_o
//  mm_start_o/mm_clear_o/mm_done_i MM pass control
//  st_req_o/st_gnt_i/st_done_i    C-tile store handshake, st_c_addr_o
module mme_tile_sched
    import mme_sched_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned SA_WIDTH = SA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [NW-1:0] mat_width_i,
    input  logic [AW-1:0] mat_a_addr_i,
    input  logic [AW-1:0] mat_b_addr_i,
    input  logic [AW-1:0] mat_c_addr_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          ld_req_o,
    input  logic          ld_gnt_i,
    input  logic          ld_done_i,
    output logic [AW-1:0] ld_a_addr_o,
    output logic [AW-1:0] ld_b_addr_o,
    output logic [AW-1:0] stride_o,
    output logic          mm_start_o,
    output logic          mm_clear_o,
    input  logic          mm_done_i,
    output logic          st_req_o,
    input  logic          st_gnt_i,
    input  logic          st_done_i,
    output logic [AW-1:0] st_c_addr_o
);

    sched_state_t  r_state;
    logic [NW-1:0] r_n;
    mat_bases_t    r_bases;
    tile_idx_t     r_ti;
    tile_idx_t     r_tj;
    tile_idx_t     r_k;

    logic r_busy;
    logic r_done;
    logic r_err;
    logic r_ld_req;
    logic r_mm_start;
    logic r_mm_clear;
    logic r_st_req;

    tile_idx_t w_nt;
    tile_idx_t w_last;
    logic      w_bad_n;
    logic      w_last_tile;
    tile_idx_t w_ti_nxt;
    tile_idx_t w_tj_nxt;
    tile_idx_t w_k_nxt;

    // N must be a non-zero multiple of the tile edge
    assign w_bad_n     = (r_n == '0) || ((AW'(r_n) % AW'(SA_WIDTH)) != '0);
    assign w_nt        = tile_idx_t'(AW'(r_n) / AW'(SA_WIDTH));
    assign w_last      = w_nt - tile_idx_t'(1);
    assign w_last_tile = (r_ti == w_last) && (r_tj == w_last);

    // Index values for the coming cycle; fed to the address generator so the
    // addresses land in the same cycle the indices do.
    always_comb begin
        w_ti_nxt = r_ti;
        w_tj_nxt = r_tj;
        w_k_nxt  = r_k;
        case (r_state)
            S_CHECK: begin
                w_ti_nxt = '0;
                w_tj_nxt = '0;
                w_k_nxt  = '0;
            end
            S_MM_WAIT: begin
                if (mm_done_i && (r_k != w_last)) begin
                    w_k_nxt = r_k + tile_idx_t'(1);
                end
            end
            S_NEXT: begin
                w_k_nxt = '0;
                if (r_tj == w_last) begin
                    w_tj_nxt = '0;
                    w_ti_nxt = r_ti + tile_idx_t'(1);
                end else begin
                    w_tj_nxt = r_tj + tile_idx_t'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, indices and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_bases    <= '0;
            r_ti       <= '0;
            r_tj       <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ld_req   <= 1'b0;
            r_mm_start <= 1'b0;
            r_mm_clear <= 1'b0;
            r_st_req   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_mm_start <= 1'b0;
            r_mm_clear <= 1'b0;
            r_ti       <= w_ti_nxt;
            r_tj       <= w_tj_nxt;
            r_k        <= w_k_nxt;

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n       <= mat_width_i;
                        r_bases.a <= mat_a_addr_i;
                        r_bases.b <= mat_b_addr_i;
                        r_bases.c <= mat_c_addr_i;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad_n) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ld_req <= 1'b1;
                        r_state  <= S_LD_REQ;
                    end
                end
                S_LD_REQ: begin
                    if (ld_gnt_i) begin
                        r_ld_req <= 1'b0;
                        if (ld_done_i) begin
                            r_mm_start <= 1'b1;
                            r_mm_clear <= (r_k == '0);
                            r_state    <= S_MM_GO;
                        end else begin
                            r_state <= S_LD_WAIT;
                        end
                    end
                end
                S_LD_WAIT: begin
                    if (ld_done_i) begin
                        r_mm_start <= 1'b1;
                        r_mm_clear <= (r_k == '0);
                        r_state    <= S_MM_GO;
                    end
                end
                S_MM_GO: begin
                    r_state <= S_MM_WAIT;
                end
                S_MM_WAIT: begin
                    if (mm_done_i) begin
                        if (r_k != w_last) begin
                            r_ld_req <= 1'b1;
                            r_state  <= S_LD_REQ;
                        end else begin
                            r_st_req <= 1'b1;
                            r_state  <= S_ST_REQ;
                        end
                    end
                end
                S_ST_REQ: begin
                    if (st_gnt_i) begin
                        r_st_req <= 1'b0;
                        r_state  <= st_done_i ? S_NEXT : S_ST_WAIT;
                    end
                end
                S_ST_WAIT: begin
                    if (st_done_i) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_last_tile) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ld_req <= 1'b1;
                        r_state  <= S_LD_REQ;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    mme_tile_addr_gen #(
        .DW       (DW),
        .SA_WIDTH (SA_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .bases_i     (r_bases),
        .n_i         (r_n),
        .ti_i        (w_ti_nxt),
        .tj_i        (w_tj_nxt),
        .k_i         (w_k_nxt),
        .ld_a_addr_o (ld_a_addr_o),
        .ld_b_addr_o (ld_b_addr_o),
        .st_c_addr_o (st_c_addr_o),
        .stride_o    (stride_o)
    );

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign ld_req_o   = r_ld_req;
    assign mm_start_o = r_mm_start;
    assign mm_clear_o = r_mm_clear;
    assign st_req_o   = r_st_req;

endmodule
